dmem_mmio_responder: RTL

- Responder for the CPU data-memory interface (daddr/dwdata/dwe in, drdata out).
- Contains a byte-writable data RAM, a 64-bit free-running cycle counter and a byte-wide console TX FIFO with a valid/ready drain port.
- Reads are combinational, so the single-cycle CPU sees load data in the same cycle. Writes commit at the rising clock edge.

---
 rtl/dmem_mmio_responder.sv | 114 +++++++++++
 1 files changed

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for a single-cycle CPU: byte-writable RAM, 64-bit cycle
// counter and a console TX FIFO, all behind one combinational-read port.
module dmem_mmio_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int          AW      = $clog2(MEM_WORDS);
  localparam int          PW      = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_END = 32'(MEM_WORDS * 4);
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

  logic [31:0]   r_mem [MEM_WORDS];
  logic [63:0]   r_cycle;
  logic [7:0]    r_buf [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_ovf;

  logic          w_in_ram;
  logic          w_is_mmio;
  logic [AW-1:0] w_word;
  logic [1:0]    w_reg;
  logic          w_empty;
  logic          w_full;
  logic          w_push_req;
  logic          w_push_ok;
  logic          w_pop;
  logic          w_ovf_evt;
  logic          w_ovf_clr;
  logic [31:0]   w_status;
  logic          w_unused;

  // Byte offset within a word is the CPU's business; decode ignores it.
  assign w_unused   = &{1'b0, daddr[1:0]};
  assign w_in_ram   = (daddr < RAM_END);
  assign w_is_mmio  = (daddr[31:4] == 28'h8000000);
  assign w_word     = daddr[AW+1:2];
  assign w_reg      = daddr[3:2];

  assign w_empty    = (r_count == 5'd0);
  assign w_full     = (r_count == DEPTH_C);
  assign w_push_req = !reset && w_is_mmio && (w_reg == 2'd2) && dwe[0];
  assign w_pop      = !reset && !w_empty && tx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);
  assign w_ovf_evt  = w_push_req && w_full && !w_pop;
  assign w_ovf_clr  = !reset && w_is_mmio && (w_reg == 2'd3) && dwe[0] && dwdata[2];
  assign w_status   = {23'd0, r_count, 1'b0, r_ovf, w_full, w_empty};

  assign tx_valid   = !w_empty;
  assign tx_data    = w_empty ? 8'd0 : r_buf[r_rd_ptr];

  always_comb begin
    drdata = 32'd0;
    if (w_in_ram) begin
      drdata = r_mem[w_word];
    end else if (w_is_mmio) begin
      case (w_reg)
        2'd0:    drdata = r_cycle[31:0];
        2'd1:    drdata = r_cycle[63:32];
        2'd3:    drdata = w_status;
        default: drdata = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_in_ram) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) r_mem[w_word][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_cycle <= 64'd0;
    else       r_cycle <= r_cycle + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_buf[r_wr_ptr] <= dwdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= 5'd0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      // Setting overflow takes priority over a same-cycle software clear.
      if (w_ovf_evt)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
    end
  end
endmodule
